// File: rtl/serial_nibble_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_nibble_rx_pkg
//   Shared definitions for the serial nibble receiver:
//     NBITS_REG  - default data word width
//     PARITY_ODD - default parity sense (0 = even, 1 = odd)
//     state_t    - receiver FSM state encoding
// -----------------------------------------------------------------------------
package serial_nibble_rx_pkg;

  localparam int NBITS_REG  = 4;
  localparam bit PARITY_ODD = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    RECOVER
  } state_t;

endpackage

// File: rtl/nibble_parity.sv
// -----------------------------------------------------------------------------
// nibble_parity
//   Combinational parity generator: the bit a transmitter places in the
//   parity slot for the given data word.
//   Ports:
//     i_data   [NBITS_REG-1:0] - received data word
//     o_parity                 - XOR of all data bits XOR PARITY_ODD
// -----------------------------------------------------------------------------
module nibble_parity #(
  parameter int NBITS_REG  = serial_nibble_rx_pkg::NBITS_REG,
  parameter bit PARITY_ODD = serial_nibble_rx_pkg::PARITY_ODD
) (
  input  logic [NBITS_REG-1:0] i_data,
  output logic                 o_parity
);

  assign o_parity = (^i_data) ^ PARITY_ODD;

endmodule

// File: rtl/serial_nibble_rx.sv
// -----------------------------------------------------------------------------
// serial_nibble_rx
//   Receives frames of: start(0), NBITS_REG data bits LSB first, parity, stop(1).
//   One bit is taken per cycle with sample_en high.
//   Ports:
//     clk_2       - clock, all state changes on the rising edge
//     reset       - asynchronous, active-low reset
//     sample_en   - bit strobe; serial_in is only looked at when high
//     serial_in   - serial line, idles high
//     data_ack    - consumer acknowledge of data_out
//     data_out    - last good word; feeds a downstream register's parallel input
//     data_valid  - data_out holds an unacknowledged word (downstream load select)
//     parity_err  - one-cycle pulse after a frame with a parity mismatch
//     frame_err   - one-cycle pulse after a frame with a 0 stop bit
//     overrun     - sticky: an unacknowledged word was overwritten
//     busy        - receiver is not in IDLE
// -----------------------------------------------------------------------------
module serial_nibble_rx #(
  parameter int NBITS_REG  = serial_nibble_rx_pkg::NBITS_REG,
  parameter bit PARITY_ODD = serial_nibble_rx_pkg::PARITY_ODD
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic                 serial_in,
  input  logic                 data_ack,
  output logic [NBITS_REG-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  import serial_nibble_rx_pkg::state_t;
  import serial_nibble_rx_pkg::IDLE;
  import serial_nibble_rx_pkg::DATA;
  import serial_nibble_rx_pkg::PARITY;
  import serial_nibble_rx_pkg::STOP;
  import serial_nibble_rx_pkg::RECOVER;

  localparam int CW = (NBITS_REG > 1) ? $clog2(NBITS_REG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS_REG - 1);

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [NBITS_REG-1:0] r_shift;
  logic                 r_par_bad;
  logic [NBITS_REG-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic                 w_exp_parity;

  nibble_parity #(
    .NBITS_REG  (NBITS_REG),
    .PARITY_ODD (PARITY_ODD)
  ) u_parity (
    .i_data   (r_shift),
    .o_parity (w_exp_parity)
  );

  // NOTE: the shift register is a plain flop vector, not a memory, so it is
  //       cleared by reset like every other state bit; a mid-frame reset
  //       therefore leaves no trace of the abandoned frame.
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_par_bad    <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      // Error outputs are single-cycle pulses.
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;

      if (r_data_valid && data_ack) begin
        r_data_valid <= 1'b0;
      end

      if (sample_en) begin
        unique case (r_state)
          IDLE: begin
            if (!serial_in) begin
              r_state <= DATA;
              r_cnt   <= '0;
            end
          end
          DATA: begin
            r_shift[r_cnt] <= serial_in;
            r_cnt          <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_state <= PARITY;
            end
          end
          PARITY: begin
            r_par_bad <= serial_in ^ w_exp_parity;
            r_state   <= STOP;
          end
          STOP: begin
            if (serial_in) begin
              if (!r_par_bad) begin
                // NOTE: non-blocking assignments take the last one written in
                //       the block, so this load overrides the acknowledge clear
                //       above when a word completes in the same cycle as data_ack.
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
                if (r_data_valid && !data_ack) begin
                  r_overrun <= 1'b1;
                end
              end else begin
                r_parity_err <= 1'b1;
              end
              r_state <= IDLE;
            end else begin
              // Broken frame: drop the word and any parity result, then wait
              // for the line to return high before hunting for a new start.
              r_frame_err <= 1'b1;
              r_state     <= RECOVER;
            end
          end
          RECOVER: begin
            if (serial_in) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_serial_nibble_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_nibble_rx
//   Directed bench for serial_nibble_rx (NBITS_REG=4, even parity).
//   Inputs change 1 time unit after the rising edge; outputs are checked at
//   the same point, i.e. they show the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_serial_nibble_rx;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       sample_en;
  logic       serial_in;
  logic       data_ack;
  logic [3:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  serial_nibble_rx #(
    .NBITS_REG  (4),
    .PARITY_ODD (1'b0)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .sample_en  (sample_en),
    .serial_in  (serial_in),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk_2 = ~clk_2;

  task automatic clk_cycle();
    @(posedge clk_2);
    #1;
  endtask

  // Idle 'gap' cycles with sample_en low, then present one sampled bit.
  task automatic send_bit(input logic b, input int gap, input logic ack);
    for (int i = 0; i < gap; i++) clk_cycle();
    sample_en = 1'b1;
    serial_in = b;
    data_ack  = ack;
    clk_cycle();
    sample_en = 1'b0;
    serial_in = 1'b1;
    data_ack  = 1'b0;
  endtask

  // Start bit followed by four data bits, LSB first.
  task automatic send_head(input logic [3:0] d, input int gap);
    send_bit(1'b0, gap, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i], gap, 1'b0);
  endtask

  task automatic ack_word();
    data_ack = 1'b1;
    clk_cycle();
    data_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) clk_cycle();
    n_vec++; if (data_out !== 4'h0) begin n_bad++; $display("FAIL reset.data_out got %h want 0", data_out); end
    n_vec++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset.data_valid got %b want 0", data_valid); end
    n_vec++; if ({parity_err, frame_err, overrun} !== 3'b000) begin n_bad++; $display("FAIL reset.flags got %b want 000", {parity_err, frame_err, overrun}); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset.busy got %b want 0", busy); end
    reset = 1'b1;
    clk_cycle();
  endtask

  task automatic test_good_frame();
    send_head(4'hA, 0);
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL good.busy_mid got %b want 1", busy); end
    send_bit(1'b0, 0, 1'b0);
    n_vec++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL good.early_valid got %b want 0", data_valid); end
    send_bit(1'b1, 0, 1'b0);
    n_vec++; if (data_out !== 4'hA) begin n_bad++; $display("FAIL good.data_out got %h want a", data_out); end
    n_vec++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL good.data_valid got %b want 1", data_valid); end
    n_vec++; if ({parity_err, frame_err} !== 2'b00) begin n_bad++; $display("FAIL good.err got %b want 00", {parity_err, frame_err}); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL good.busy_end got %b want 0", busy); end
    ack_word();
    n_vec++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL good.ack_clear got %b want 0", data_valid); end
    ack_word();
    n_vec++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL good.ack_idle got %b want 0", data_valid); end
  endtask

  task automatic test_parity_err();
    send_head(4'hA, 0);
    send_bit(1'b1, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    n_vec++; if (parity_err !== 1'b1) begin n_bad++; $display("FAIL par.pulse got %b want 1", parity_err); end
    n_vec++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL par.data_valid got %b want 0", data_valid); end
    n_vec++; if (data_out !== 4'hA) begin n_bad++; $display("FAIL par.data_out got %h want a", data_out); end
    clk_cycle();
    n_vec++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL par.pulse_end got %b want 0", parity_err); end
  endtask

  task automatic test_frame_err();
    send_head(4'h3, 0);
    send_bit(1'b0, 0, 1'b0);
    send_bit(1'b0, 0, 1'b0);
    n_vec++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL frm.pulse got %b want 1", frame_err); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL frm.busy got %b want 1", busy); end
    n_vec++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL frm.data_valid got %b want 0", data_valid); end
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0, 0, 1'b0);
      n_vec++; if ({busy, frame_err} !== 2'b10) begin n_bad++; $display("FAIL frm.recover%0d busy/ferr got %b want 10", i, {busy, frame_err}); end
    end
    send_bit(1'b1, 0, 1'b0);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL frm.idle got %b want 0", busy); end
    n_vec++; if ({data_out, data_valid} !== {4'hA, 1'b0}) begin n_bad++; $display("FAIL frm.data got %h/%b want a/0", data_out, data_valid); end
  endtask

  task automatic test_overrun();
    send_head(4'h5, 0); send_bit(1'b0, 0, 1'b0); send_bit(1'b1, 0, 1'b0);
    n_vec++; if ({data_out, data_valid, overrun} !== {4'h5, 1'b1, 1'b0}) begin n_bad++; $display("FAIL ovr.first got %h/%b/%b want 5/1/0", data_out, data_valid, overrun); end
    send_head(4'h9, 0); send_bit(1'b0, 0, 1'b0); send_bit(1'b1, 0, 1'b0);
    n_vec++; if (data_out !== 4'h9) begin n_bad++; $display("FAIL ovr.data_out got %h want 9", data_out); end
    n_vec++; if ({data_valid, overrun} !== 2'b11) begin n_bad++; $display("FAIL ovr.valid_ovr got %b want 11", {data_valid, overrun}); end
    ack_word();
    n_vec++; if ({data_valid, overrun} !== 2'b01) begin n_bad++; $display("FAIL ovr.sticky got %b want 01", {data_valid, overrun}); end
    reset = 1'b0;
    #2;
    n_vec++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr.reset_clear got %b want 0", overrun); end
    clk_cycle();
    reset = 1'b1;
    clk_cycle();
    send_head(4'h5, 0); send_bit(1'b0, 0, 1'b0); send_bit(1'b1, 0, 1'b0);
    send_head(4'h9, 0); send_bit(1'b0, 0, 1'b0); send_bit(1'b1, 0, 1'b1);
    n_vec++; if ({data_out, data_valid, overrun} !== {4'h9, 1'b1, 1'b0}) begin n_bad++; $display("FAIL ovr.ack_same got %h/%b/%b want 9/1/0", data_out, data_valid, overrun); end
    ack_word();
  endtask

  task automatic test_reset_midframe();
    send_bit(1'b0, 0, 1'b0);
    send_bit(1'b0, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    reset = 1'b0;
    #2;
    n_vec++; if ({data_out, data_valid} !== 5'h00) begin n_bad++; $display("FAIL rst.data got %h/%b want 0/0", data_out, data_valid); end
    n_vec++; if ({parity_err, frame_err, overrun, busy} !== 4'b0000) begin n_bad++; $display("FAIL rst.flags got %b want 0000", {parity_err, frame_err, overrun, busy}); end
    clk_cycle();
    reset = 1'b1;
    clk_cycle();
    send_head(4'h6, 0);
    send_bit(1'b0, 0, 1'b0);
    n_vec++; if ({data_out, data_valid} !== 5'h00) begin n_bad++; $display("FAIL rst.before_stop got %h/%b want 0/0", data_out, data_valid); end
    send_bit(1'b1, 0, 1'b0);
    n_vec++; if ({data_out, data_valid} !== {4'h6, 1'b1}) begin n_bad++; $display("FAIL rst.new_frame got %h/%b want 6/1", data_out, data_valid); end
    ack_word();
  endtask

  task automatic test_sparse();
    send_head(4'hF, 3);
    send_bit(1'b0, 3, 1'b0);
    for (int i = 0; i < 3; i++) clk_cycle();
    n_vec++; if ({data_valid, busy} !== 2'b01) begin n_bad++; $display("FAIL sparse.pre_stop got %b want 01", {data_valid, busy}); end
    send_bit(1'b1, 0, 1'b0);
    n_vec++; if ({data_out, data_valid} !== {4'hF, 1'b1}) begin n_bad++; $display("FAIL sparse.data got %h/%b want f/1", data_out, data_valid); end
    n_vec++; if ({parity_err, frame_err, busy} !== 3'b000) begin n_bad++; $display("FAIL sparse.flags got %b want 000", {parity_err, frame_err, busy}); end
  endtask

  initial begin
    reset     = 1'b0;
    sample_en = 1'b0;
    serial_in = 1'b1;
    data_ack  = 1'b0;
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_sparse();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
